// File: rtl/xbar_registered.sv
// Parametrised N x N router crossbar with registered data/feedback paths,
// per-output lowest-index priority selection and saturating error counters.

`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef DATA_VALID_WIDTH
`define DATA_VALID_WIDTH 1
`endif
`ifndef BUFFERSIZE_WIDTH
`define BUFFERSIZE_WIDTH 3
`endif

module xbar_registered #(
  parameter int P_PORTS          = 5,
  parameter int P_DATA_WIDTH     = `FLIT_WIDTH + `DATA_VALID_WIDTH,
  parameter int P_FEEDBACK_WIDTH = `BUFFERSIZE_WIDTH,
  parameter int P_CNT_WIDTH      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [P_PORTS*P_PORTS-1:0]           request,
  input  logic [P_PORTS*P_DATA_WIDTH-1:0]      data_in,
  output logic [P_PORTS*P_DATA_WIDTH-1:0]      data_out,
  input  logic [P_PORTS*P_FEEDBACK_WIDTH-1:0]  feedback_in,
  output logic [P_PORTS*P_FEEDBACK_WIDTH-1:0]  feedback_out,
  output logic [P_PORTS*P_PORTS-1:0]           grant,
  output logic [P_CNT_WIDTH-1:0]               conflict_cnt,
  output logic [P_CNT_WIDTH-1:0]               malformed_cnt,
  output logic                                 err_sticky,
  input  logic                                 err_clr
);

  // Increments can reach P_PORTS, so they need one bit beyond clog2.
  localparam int INC_W = $clog2(P_PORTS) + 1;
  localparam int SUM_W = ((P_CNT_WIDTH > INC_W) ? P_CNT_WIDTH : INC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({P_CNT_WIDTH{1'b1}});

  logic [P_PORTS-1:0]                  slice_valid;
  logic [P_PORTS-1:0]                  slice_malformed;
  logic [INC_W-1:0]                    ones;
  logic [INC_W-1:0]                    malformed_inc;
  logic [INC_W-1:0]                    conflict_inc;
  logic                                found;
  logic                                multi;
  logic [P_PORTS*P_PORTS-1:0]          grant_d;
  logic [P_PORTS*P_DATA_WIDTH-1:0]     data_d;
  logic [P_PORTS*P_FEEDBACK_WIDTH-1:0] feedback_d;
  logic [P_CNT_WIDTH-1:0]              conflict_cnt_d;
  logic [P_CNT_WIDTH-1:0]              malformed_cnt_d;

  function automatic logic [P_CNT_WIDTH-1:0] sat_add(
    input logic [P_CNT_WIDTH-1:0] cnt,
    input logic [INC_W-1:0]       inc
  );
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cnt) + SUM_W'(inc);
    if (sum > CNT_MAX) return '1;
    return sum[P_CNT_WIDTH-1:0];
  endfunction

  // Request validation: exactly one bit is a valid slice, more than one is malformed.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    slice_valid     = '0;
    slice_malformed = '0;
    malformed_inc   = '0;
    ones            = '0;
    for (int i = 0; i < P_PORTS; i++) begin
      ones = '0;
      for (int j = 0; j < P_PORTS; j++) begin
        // NOTE: blocking assignments here so each partial sum is visible to the next line.
        ones = ones + INC_W'(request[i*P_PORTS+j]);
      end
      slice_valid[i]     = (ones == INC_W'(1));
      slice_malformed[i] = (ones > INC_W'(1));
      malformed_inc      = malformed_inc + INC_W'(slice_malformed[i]);
    end
  end

  // Per-output selection: the lowest-index valid requester wins.
  always_comb begin
    grant_d      = '0;
    data_d       = '0;
    feedback_d   = '0;
    conflict_inc = '0;
    found        = 1'b0;
    multi        = 1'b0;
    for (int j = 0; j < P_PORTS; j++) begin
      found = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < P_PORTS; i++) begin
        if (slice_valid[i] && request[i*P_PORTS+j]) begin
          if (found) begin
            multi = 1'b1;
          end else begin
            found                                              = 1'b1;
            grant_d[i*P_PORTS+j]                               = 1'b1;
            data_d[j*P_DATA_WIDTH +: P_DATA_WIDTH]             = data_in[i*P_DATA_WIDTH +: P_DATA_WIDTH];
            feedback_d[i*P_FEEDBACK_WIDTH +: P_FEEDBACK_WIDTH] = feedback_in[j*P_FEEDBACK_WIDTH +: P_FEEDBACK_WIDTH];
          end
        end
      end
      conflict_inc = conflict_inc + INC_W'(multi);
    end
  end

  always_comb begin
    conflict_cnt_d  = sat_add(conflict_cnt, conflict_inc);
    malformed_cnt_d = sat_add(malformed_cnt, malformed_inc);
  end

  // Datapath register stage: one cycle latency, fresh connection matrix every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state here is plain flops, so everything is cleared by the async reset.
    if (!rst_n) begin
      grant        <= '0;
      data_out     <= '0;
      feedback_out <= '0;
    end else begin
      // NOTE: non-blocking assignments for state so all flops update together at the edge.
      grant        <= grant_d;
      data_out     <= data_d;
      feedback_out <= feedback_d;
    end
  end

  // Error accounting; a same-cycle clear overrides any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt  <= '0;
      malformed_cnt <= '0;
      err_sticky    <= 1'b0;
    end else if (err_clr) begin
      conflict_cnt  <= '0;
      malformed_cnt <= '0;
      err_sticky    <= 1'b0;
    end else begin
      conflict_cnt  <= conflict_cnt_d;
      malformed_cnt <= malformed_cnt_d;
      if ((conflict_inc != '0) || (malformed_inc != '0)) begin
        err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xbar_registered.sv
// Self-checking bench for xbar_registered: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.

module tb_xbar_registered;

  localparam int P    = 5;
  localparam int DW   = 16;
  localparam int FW   = 4;
  localparam int CW   = 4;
  localparam int RW   = P * P;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            err_clr = 1'b0;
  logic [RW-1:0]   request = '0;
  logic [P*DW-1:0] data_in = '0;
  logic [P*DW-1:0] data_out;
  logic [P*FW-1:0] feedback_in = '0;
  logic [P*FW-1:0] feedback_out;
  logic [RW-1:0]   grant;
  logic [CW-1:0]   conflict_cnt;
  logic [CW-1:0]   malformed_cnt;
  logic            err_sticky;

  xbar_registered #(
    .P_PORTS(P), .P_DATA_WIDTH(DW), .P_FEEDBACK_WIDTH(FW), .P_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .request(request), .data_in(data_in),
    .data_out(data_out), .feedback_in(feedback_in), .feedback_out(feedback_out),
    .grant(grant), .conflict_cnt(conflict_cnt), .malformed_cnt(malformed_cnt),
    .err_sticky(err_sticky), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference-model expectations for the most recent edge.
  logic [RW-1:0]   exp_grant;
  logic [P*DW-1:0] exp_data;
  logic [P*FW-1:0] exp_fb;
  int              exp_conf = 0;
  int              exp_mal = 0;
  int              exp_sticky = 0;

  typedef struct {
    logic [RW-1:0]   req;
    logic [P*DW-1:0] din;
    logic [P*FW-1:0] fin;
    logic [RW-1:0]   g;
    logic [P*DW-1:0] dout;
    logic [P*FW-1:0] fout;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: collect valid requesters per output in input order; first one wins.
  task automatic model(input logic [RW-1:0] req, input logic [P*DW-1:0] din,
                       input logic [P*FW-1:0] fin, output logic [RW-1:0] g,
                       output logic [P*DW-1:0] dout, output logic [P*FW-1:0] fout,
                       output int nc, output int nm);
    int q[P][$];
    logic [P-1:0] s;
    g = '0; dout = '0; fout = '0; nc = 0; nm = 0;
    for (int i = 0; i < P; i++) begin
      s = req[i*P +: P];
      if ($countones(s) > 1) nm++;
      else if ($countones(s) == 1)
        for (int j = 0; j < P; j++) if (s[j]) q[j].push_back(i);
    end
    for (int j = 0; j < P; j++) begin
      if (q[j].size() >= 2) nc++;
      if (q[j].size() > 0) begin
        g[q[j][0]*P + j]          = 1'b1;
        dout[j*DW +: DW]          = din[q[j][0]*DW +: DW];
        fout[q[j][0]*FW +: FW]    = fin[j*FW +: FW];
      end
    end
  endtask

  task automatic cycle(input logic [RW-1:0] req, input logic [P*DW-1:0] din,
                       input logic [P*FW-1:0] fin, input logic clr);
    int nc, nm;
    @(negedge clk);
    request = req; data_in = din; feedback_in = fin; err_clr = clr;
    model(req, din, fin, exp_grant, exp_data, exp_fb, nc, nm);
    @(posedge clk);
    #1;
    if (clr) begin
      exp_conf = 0; exp_mal = 0; exp_sticky = 0;
    end else begin
      exp_conf = (exp_conf + nc > CMAX) ? CMAX : exp_conf + nc;
      exp_mal  = (exp_mal + nm > CMAX) ? CMAX : exp_mal + nm;
      if (nc + nm > 0) exp_sticky = 1;
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, ".conflict_cnt"},  128'(conflict_cnt),  128'(exp_conf));
    check({tag, ".malformed_cnt"}, 128'(malformed_cnt), 128'(exp_mal));
    check({tag, ".err_sticky"},    128'(err_sticky),    128'(exp_sticky));
  endtask

  task automatic check_model(input string tag);
    check({tag, ".grant"},        128'(grant),        128'(exp_grant));
    check({tag, ".data_out"},     128'(data_out),     128'(exp_data));
    check({tag, ".feedback_out"}, 128'(feedback_out), 128'(exp_fb));
    check_counters(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".grant"},         128'(grant),         '0);
    check({tag, ".data_out"},      128'(data_out),      '0);
    check({tag, ".feedback_out"},  128'(feedback_out),  '0);
    check({tag, ".conflict_cnt"},  128'(conflict_cnt),  '0);
    check({tag, ".malformed_cnt"}, 128'(malformed_cnt), '0);
    check({tag, ".err_sticky"},    128'(err_sticky),    '0);
  endtask

  function automatic logic [RW-1:0] rand_req();
    logic [RW-1:0] r;
    int k;
    r = '0;
    for (int i = 0; i < P; i++) begin
      k = $urandom_range(9);
      if (k >= 2 && k < 8) r[i*P + $urandom_range(P-1)] = 1'b1;
      else if (k >= 8)     r[i*P +: P] = P'($urandom);
    end
    return r;
  endfunction

  function automatic logic [P*DW-1:0] rand_data();
    logic [P*DW-1:0] d;
    for (int i = 0; i < P; i++) d[i*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  function automatic logic [P*FW-1:0] rand_fb();
    logic [P*FW-1:0] f;
    for (int i = 0; i < P; i++) f[i*FW +: FW] = FW'($urandom);
    return f;
  endfunction

  localparam logic [RW-1:0] PERM_REQ = 25'h0182082;
  localparam logic [RW-1:0] CONF_REQ = 25'h0100420;
  localparam logic [RW-1:0] MAL_REQ  = 25'h0030000;

  initial begin
    logic [P*DW-1:0] din;
    logic [P*FW-1:0] fin;
    logic [P*DW-1:0] dtab;
    logic [P*FW-1:0] ftab;

    // Input i carries 0x11*(i+1); output j feeds back j+1.
    dtab = 80'h0055_0044_0033_0022_0011;
    ftab = 20'h54321;
    vecs[0] = '{req: 25'h0000008, din: dtab, fin: ftab, g: 25'h0000008,
                dout: 80'h0000_0011_0000_0000_0000, fout: 20'h00004};
    vecs[1] = '{req: PERM_REQ, din: dtab, fin: ftab, g: PERM_REQ,
                dout: 80'h0044_0033_0022_0011_0055, fout: 20'h15432};
    vecs[2] = '{req: CONF_REQ, din: dtab, fin: ftab, g: 25'h0000020,
                dout: 80'h0000_0000_0000_0000_0022, fout: 20'h00010};
    vecs[3] = '{req: 25'h0030010, din: dtab, fin: ftab, g: 25'h0000010,
                dout: 80'h0011_0000_0000_0000_0000, fout: 20'h00005};
    vecs[4] = '{req: '0, din: dtab, fin: ftab, g: '0, dout: '0, fout: '0};

    // Reset held: random traffic must not reach the outputs.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      request = rand_req(); data_in = rand_data(); feedback_in = rand_fb();
      err_clr = 1'(c);
      @(posedge clk);
      #1;
      check_all_zero($sformatf("reset_hold%0d", c));
    end
    @(negedge clk);
    request = '0; err_clr = 1'b0; rst_n = 1'b1;

    // First transfer after release.
    fin = rand_fb();
    din = '0;
    din[0 +: DW] = 16'h00A5;
    cycle(25'h0000008, din, fin, 1'b0);
    check("first.data_out3", 128'(data_out[3*DW +: DW]), 128'h00A5);
    check("first.grant",     128'(grant), 128'h8);
    check("first.fb0",       128'(feedback_out[0 +: FW]), 128'(fin[3*FW +: FW]));
    check_model("first");

    // Directed vector table.
    for (int v = 0; v < 5; v++) begin
      cycle(vecs[v].req, vecs[v].din, vecs[v].fin, 1'b0);
      check($sformatf("vec%0d.grant", v),    128'(grant),        128'(vecs[v].g));
      check($sformatf("vec%0d.data", v),     128'(data_out),     128'(vecs[v].dout));
      check($sformatf("vec%0d.fb", v),       128'(feedback_out), 128'(vecs[v].fout));
      check_counters($sformatf("vec%0d", v));
    end

    // Permutation with distinct data, async reset pulse between edges mid-stream.
    cycle('0, '0, '0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < P; i++) din[i*DW +: DW] = DW'(c * 16 + i + 1);
      fin = rand_fb();
      cycle(PERM_REQ, din, fin, 1'b0);
      for (int j = 0; j < P; j++)
        check($sformatf("perm%0d.out%0d", c, j), 128'(data_out[j*DW +: DW]),
              128'(din[((j + 4) % P)*DW +: DW]));
      check($sformatf("perm%0d.conflict", c), 128'(conflict_cnt), '0);
      check_model($sformatf("perm%0d", c));
      if (c == 5) begin
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        rst_n = 1'b1;
        exp_conf = 0; exp_mal = 0; exp_sticky = 0;
      end
    end

    // Conflict on output 0 from inputs 1, 2 and 4.
    cycle('0, '0, '0, 1'b1);
    din = '0;
    din[1*DW +: DW] = 16'h0011;
    din[2*DW +: DW] = 16'h0022;
    din[4*DW +: DW] = 16'h0044;
    cycle(CONF_REQ, din, ftab, 1'b0);
    check("conf.data0",  128'(data_out[0 +: DW]), 128'h11);
    check("conf.grant",  128'(grant), 128'h20);
    check("conf.fb2",    128'(feedback_out[2*FW +: FW]), '0);
    check("conf.fb4",    128'(feedback_out[4*FW +: FW]), '0);
    check("conf.cnt",    128'(conflict_cnt), 128'd1);
    check("conf.sticky", 128'(err_sticky), 128'd1);

    // Malformed slice 3 for three cycles, then clear wins over a new malformed request.
    cycle('0, '0, '0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      cycle(MAL_REQ, dtab, ftab, 1'b0);
      check($sformatf("mal%0d.out1", c),  128'(data_out[1*DW +: DW]), '0);
      check($sformatf("mal%0d.out2", c),  128'(data_out[2*DW +: DW]), '0);
      check($sformatf("mal%0d.fb3", c),   128'(feedback_out[3*FW +: FW]), '0);
      check($sformatf("mal%0d.grant", c), 128'(grant), '0);
    end
    check("mal.cnt", 128'(malformed_cnt), 128'd3);
    cycle(MAL_REQ, dtab, ftab, 1'b1);
    check("malclr.cnt",    128'(malformed_cnt), '0);
    check("malclr.sticky", 128'(err_sticky), '0);

    // Saturation of the 4-bit conflict counter.
    for (int c = 0; c < 20; c++) begin
      cycle(CONF_REQ, rand_data(), rand_fb(), 1'b0);
      check_counters($sformatf("sat%0d", c));
    end
    check("sat.final", 128'(conflict_cnt), 128'd15);

    // Randomized traffic against the reference model.
    cycle('0, '0, '0, 1'b1);
    for (int c = 0; c < 300; c++) begin
      cycle(rand_req(), rand_data(), rand_fb(), ($urandom_range(19) == 0));
      check_model($sformatf("rand%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xbar_registered.md
Name: xbar_registered

Overview:
- Parametrised successor to the fixed 5x5 router crossbar: N input ports to N output ports, with registered data and feedback paths.
- Per-output priority selection resolves conflicting requests in hardware instead of relying on fault-free switch allocation.
- Conflict and malformed requests are detected and counted.
- Sits between switch allocator/input buffers and router output links; feedback (credit/buffer-occupancy) travels from output side back to the winning input.

Parameters:
- P_PORTS, 5, number of input ports and number of output ports (2..16).
- P_DATA_WIDTH, `FLIT_WIDTH + `DATA_VALID_WIDTH, flit plus valid bits per port.
- P_FEEDBACK_WIDTH, `BUFFERSIZE_WIDTH, feedback bits per port.
- P_CNT_WIDTH, 16, width of the saturating error counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- request  in  P_PORTS*P_PORTS  input i requests output j when bit [i*P_PORTS+j] is set; each slice must be one-hot or zero.
- data_in  in  P_PORTS*P_DATA_WIDTH  flit from input i at [i*P_DATA_WIDTH +: P_DATA_WIDTH].
- data_out  out  P_PORTS*P_DATA_WIDTH  flit to output j, registered.
- feedback_in  in  P_PORTS*P_FEEDBACK_WIDTH  feedback from output j.
- feedback_out  out  P_PORTS*P_FEEDBACK_WIDTH  feedback to input i, registered.
- grant  out  P_PORTS*P_PORTS  registered granted connection matrix, same layout as request.
- conflict_cnt  out  P_CNT_WIDTH  saturating count of output-cycles with more than one valid requester.
- malformed_cnt  out  P_CNT_WIDTH  saturating count of input-cycles with a multi-hot request slice.
- err_sticky  out  1  set on any conflict or malformed request.
- err_clr  in  1  synchronous clear of both counters and err_sticky.

Behaviour:
- Reset (rst_n low, asynchronous): data_out, feedback_out, grant, conflict_cnt, malformed_cnt and err_sticky all go to 0. Reset mid-transfer discards the in-flight registered cycle. First valid output appears one cycle after release.
- Request validation (combinational):
  - A slice is valid if exactly one bit is set.
  - Zero slice means idle and is not an error.
  - A multi-hot slice is malformed: the input is treated as idle, so it gets no grant, no data and feedback 0.
- Selection, per output j (combinational): the winner is the lowest-index input i with a valid slice whose bit j is set. Higher-index requesters of the same output lose that cycle and receive no grant.
- Registered stage, on each clk edge:
  - grant[i*P+j] <= 1 iff input i won output j.
  - data_out[j] <= data_in[winner]; 0 if there is no winner.
  - feedback_out[i] <= feedback_in[j] where input i won output j; 0 if input i has no grant.
  - Latency is exactly 1 cycle for data and feedback, with no combinational input-to-output path.
  - Full throughput: a new connection matrix every cycle, independent of the previous cycle.
- Error accounting, per cycle:
  - conflict_cnt increments by the number of outputs with two or more valid requesters.
  - malformed_cnt increments by the number of malformed slices.
  - Both saturate at all-ones; they do not wrap.
  - err_sticky sets if either increment is nonzero.
  - err_clr has priority over the same-cycle increment: the result is 0, and err_sticky is 0.
- Width rules: increments are summed at full width (clog2(P_PORTS)+1 bits) and then added with saturation, so that count+inc > max clamps to max.
- The block does not inspect the flit valid bit; a granted data_in is forwarded verbatim, including an invalid flit.

Test Plan:
- Reset: hold rst_n=0, drive random request/data → all outputs 0. Release rst_n; request[0*5+3]=1, data_in[0]=0xA5 → next cycle data_out[3]=0xA5, grant bit 3 set, feedback_out[0]=feedback_in[3].
- Full permutation (P_PORTS=5): input i→output (i+1)%5, all slices one-hot, with distinct data each cycle for 10 cycles → every data_out[j] equals data_in[(j+4)%5] from the previous cycle; conflict_cnt stays 0.
- Conflict: inputs 1, 2 and 4 all request output 0, with data 0x11/0x22/0x44 → data_out[0]=0x11, only grant[1*5+0]=1, feedback_out[2]=feedback_out[4]=0, conflict_cnt=1, err_sticky=1.
- Malformed: request slice 3 = 5'b00110 for 3 cycles → outputs 1 and 2 get 0, malformed_cnt=3. Then err_clr=1 in the same cycle as another malformed request → malformed_cnt=0 and err_sticky=0.
- Saturation (P_CNT_WIDTH=4): 20 conflict cycles → conflict_cnt stays at 15, with no wrap.
- Async reset mid-stream: pulse rst_n low between clock edges during the permutation traffic → outputs 0 immediately. After release, the first edge produces correct data for the current requests.
